// File: rtl/control_seq.sv
// Fetch/execute sequencer with instruction register, memory wait handling,
// conditional jump resolution, halt detection and a retired-instruction count.
module control_seq #(
  parameter  int SRC_W  = 2,
  parameter  int DEST_W = 3,
  parameter  int CNT_W  = 16,
  localparam int IW     = 2 + SRC_W + DEST_W + 1,
  localparam int NSRC   = 1 << SRC_W,
  localparam int NDEST  = 1 << DEST_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [IW-1:0]    bus_in,
  input  logic             mem_ready,
  input  logic             a_is_zero,
  input  logic             flag_carry,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_from_pc,
  output logic             load_ir,
  output logic             pc_inc,
  output logic             load_pc,
  output logic [NDEST-1:0] load_dest,
  output logic [NSRC-1:0]  src_sel_n,
  output logic             do_subtract,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {
    FETCH,
    EXEC,
    HALT
  } state_t;

  state_t state, nextState;

  logic [IW-1:0]    ir;
  logic [CNT_W-1:0] count;
  logic             retire;

  logic              b7, b6, idx;
  logic [SRC_W-1:0]  src;
  logic [DEST_W-1:0] dest;
  logic              imm, destPc, destStore, destHalt;
  logic              memCycle, done, jump;

  assign b7  = ir[IW-1];
  assign b6  = ir[IW-2];
  assign src = ir[IW-3 -: SRC_W];
  assign dest = ir[DEST_W:1];
  assign idx = ir[0];
  assign imm = ~idx;

  assign destPc    = dest == DEST_W'(1);
  assign destStore = dest == DEST_W'(5);
  assign destHalt  = dest == {DEST_W{1'b1}};
  assign memCycle  = (src == '0) | destStore;

  assign jump = destPc & ((b6 & a_is_zero) | (b7 & flag_carry) | (b6 & b7));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= FETCH;
      ir    <= '0;
      count <= '0;
    end else begin
      state <= nextState;
      if (load_ir) ir <= bus_in;
      if (retire) count <= count + CNT_W'(1);
    end
  end

  always_comb begin
    nextState    = state;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    addr_from_pc = 1'b0;
    load_ir      = 1'b0;
    pc_inc       = 1'b0;
    load_pc      = 1'b0;
    load_dest    = '0;
    src_sel_n    = '1;
    do_subtract  = 1'b0;
    halted       = 1'b0;
    retire       = 1'b0;
    done         = 1'b0;
    if (reset_n) begin
      unique case (state)
        FETCH: begin
          mem_req      = 1'b1;
          addr_from_pc = 1'b1;
          if (mem_ready) begin
            load_ir   = 1'b1;
            pc_inc    = 1'b1;
            nextState = EXEC;
          end
        end
        EXEC: begin
          src_sel_n   = ~(NSRC'(1) << src);
          do_subtract = b6;
          if (destHalt) begin
            nextState = HALT;
          end else begin
            if (memCycle) begin
              mem_req      = 1'b1;
              addr_from_pc = imm;
              mem_we       = destStore;
              done         = mem_ready;
            end else begin
              done = 1'b1;
            end
            // Strobes fire only on the cycle the instruction completes
            if (done) begin
              load_pc = jump;
              if (!destPc && !destStore) load_dest[dest] = 1'b1;
              pc_inc    = memCycle & imm & ~jump;
              retire    = 1'b1;
              nextState = FETCH;
            end
          end
        end
        HALT: begin
          halted = 1'b1;
        end
        default: nextState = FETCH;
      endcase
    end
  end

  assign retired = reset_n ? count : '0;

endmodule

// File: tb/tb_control_seq.sv
// Randomized bench for control_seq: a transaction-level model predicts
// every cycle's outputs from the instruction fields and wait counts.
module tb_control_seq;

  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [7:0]    bus_in = '0;
  logic          mem_ready = 1'b0;
  logic          a_is_zero = 1'b0;
  logic          flag_carry = 1'b0;
  logic          mem_req, mem_we, addr_from_pc, load_ir;
  logic          pc_inc, load_pc, do_subtract, halted;
  logic [7:0]    load_dest;
  logic [3:0]    src_sel_n;
  logic [CW-1:0] retired;

  int errs = 0;
  int checks = 0;
  int expRet = 0;

  always #5 clk = ~clk;

  control_seq #(.SRC_W(2), .DEST_W(3), .CNT_W(CW)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus_in(bus_in),
    .mem_ready(mem_ready),
    .a_is_zero(a_is_zero),
    .flag_carry(flag_carry),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .addr_from_pc(addr_from_pc),
    .load_ir(load_ir),
    .pc_inc(pc_inc),
    .load_pc(load_pc),
    .load_dest(load_dest),
    .src_sel_n(src_sel_n),
    .do_subtract(do_subtract),
    .halted(halted),
    .retired(retired)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [19:0] ov(
    input bit req, input bit we, input bit afp, input bit lir,
    input bit pinc, input bit lpc, input logic [7:0] ld,
    input logic [3:0] ss, input bit sub, input bit hlt);
    return {req, we, afp, lir, pinc, lpc, ld, ss, sub, hlt};
  endfunction

  task automatic cyc(input bit rn, input bit rdy, input logic [7:0] bus,
                     input bit z, input bit c, input logic [19:0] e,
                     input string tag);
    logic [19:0] o;
    @(negedge clk);
    reset_n    = rn;
    mem_ready  = rdy;
    bus_in     = bus;
    a_is_zero  = z;
    flag_carry = c;
    #2;
    o = {mem_req, mem_we, addr_from_pc, load_ir, pc_inc, load_pc,
         load_dest, src_sel_n, do_subtract, halted};
    chk(tag, {o, retired}, {e, CW'(expRet)});
    @(posedge clk);
  endtask

  function automatic logic [19:0] idle();
    return ov(0, 0, 0, 0, 0, 0, 8'h00, 4'hF, 0, 0);
  endfunction

  task automatic doReset();
    expRet = 0;
    cyc(0, 1'($urandom), 8'($urandom), 0, 0, idle(), "reset");
  endtask

  task automatic runInstr(input logic [7:0] ins, input int fw,
                          input int ew, input bit z, input bit c);
    bit          b7, b6, idx, memc, jump, pinc;
    int          src, dest;
    logic [3:0]  one;
    logic [3:0]  ss;
    logic [7:0]  ld;
    b7   = ins[7];
    b6   = ins[6];
    src  = int'(ins[5:4]);
    dest = int'(ins[3:1]);
    idx  = ins[0];
    one  = 4'd1;
    ss   = ~(one << src);
    memc = (src == 0) || (dest == 5);
    for (int i = 0; i < fw; i++)
      cyc(1, 0, 8'($urandom), 1'($urandom), 1'($urandom),
          ov(1, 0, 1, 0, 0, 0, 8'h00, 4'hF, 0, 0), "fetchWait");
    cyc(1, 1, ins, 1'($urandom), 1'($urandom),
        ov(1, 0, 1, 1, 1, 0, 8'h00, 4'hF, 0, 0), "fetch");
    if (dest == 7) begin
      cyc(1, 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
          ov(0, 0, 0, 0, 0, 0, 8'h00, ss, b6, 0), "execHalt");
      return;
    end
    if (memc)
      for (int i = 0; i < ew; i++)
        cyc(1, 0, 8'($urandom), 1'($urandom), 1'($urandom),
            ov(1, dest == 5, !idx, 0, 0, 0, 8'h00, ss, b6, 0), "execWait");
    jump = (dest == 1) && ((b6 && z) || (b7 && c) || (b6 && b7));
    ld   = (dest == 1 || dest == 5) ? 8'h00 : 8'(1 << dest);
    pinc = memc && !idx && !jump;
    cyc(1, memc ? 1'b1 : 1'($urandom), 8'($urandom), z, c,
        ov(memc, memc && dest == 5, memc && !idx, 0, pinc, jump,
           ld, ss, b6, 0), "exec");
    expRet = (expRet + 1) % (1 << CW);
  endtask

  initial begin
    logic [7:0] ins;
    doReset();
    doReset();
    runInstr(8'h26, 0, 0, 0, 0);
    runInstr(8'h04, 0, 3, 0, 0);
    runInstr(8'h2B, 1, 0, 1, 1);
    runInstr(8'h42, 0, 0, 1, 0);
    runInstr(8'h42, 0, 1, 0, 1);
    runInstr(8'hC2, 0, 0, 0, 0);
    runInstr(8'h82, 2, 0, 0, 1);
    for (int n = 0; n < 1100; n++) begin
      do ins = 8'($urandom); while (ins[3:1] == 3'd7);
      runInstr(ins, $urandom_range(0, 2), $urandom_range(0, 2),
               1'($urandom), 1'($urandom));
    end
    cyc(1, 0, 8'h00, 0, 0, ov(1, 0, 1, 0, 0, 0, 8'h00, 4'hF, 0, 0),
        "fetchWait");
    doReset();
    cyc(1, 0, 8'h00, 0, 0, ov(1, 0, 1, 0, 0, 0, 8'h00, 4'hF, 0, 0),
        "restart");
    runInstr(8'h26, 0, 0, 0, 0);
    runInstr(8'h3E, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++)
      cyc(1, 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
          ov(0, 0, 0, 0, 0, 0, 8'h00, 4'hF, 0, 1), "halt");
    doReset();
    cyc(1, 1, 8'h26, 0, 0, ov(1, 0, 1, 1, 1, 0, 8'h00, 4'hF, 0, 0),
        "postHalt");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/control_seq.md
# control_seq

Multi-cycle, parametrised successor to the nic8 combinational control decoder. It owns a fetch/execute state machine and an internal instruction register. It handles a memory wait-state handshake, performs conditional jump resolution and detects halt, and counts retired instructions. It sits between the memory/bus interface and the datapath register file.

## Interface
Parameters:
- SRC_W, default 2: source field width; the source select is one-hot over 2**SRC_W.
- DEST_W, default 3: destination field width; the load strobes are one-hot over 2**DEST_W.
- CNT_W, default 16: retired-instruction counter width.
- IW, derived as 2+SRC_W+DEST_W+1 (8 at defaults): instruction width.

Ports:
- clk, in, 1: the single clock, rising edge.
- reset_n, in, 1: reset, synchronous and active-low.
- bus_in, in, IW: memory read data, captured into IR.
- mem_ready, in, 1: the current memory request completes this cycle.
- a_is_zero, in, 1: zero flag from the datapath.
- flag_carry, in, 1: carry flag from the datapath.
- mem_req, out, 1: memory access requested this cycle.
- mem_we, out, 1: the request is a write (store).
- addr_from_pc, out, 1: 1 means address from PC, 0 means address from X.
- load_ir, out, 1: IR captured this cycle.
- pc_inc, out, 1: PC increments this cycle.
- load_pc, out, 1: taken jump; PC loads from the bus.
- load_dest, out, 2**DEST_W: one-hot destination load strobe.
- src_sel_n, out, 2**SRC_W: one-hot active-low bus source select.
- do_subtract, out, 1: ALU subtract mode.
- halted, out, 1: the block is in the HALT state.
- retired, out, CNT_W: count of completed instructions.

## Operation
- The IR fields, MSB first, are: b7, b6, src[SRC_W], dest[DEST_W], idx. The immediate flag is ~idx.
- Destination codes: 0 IR, 1 PC, 5 store-to-memory, 2**DEST_W-1 HALT. All other codes are plain register loads.
- Source 0 is memory. An access is a mem_cycle when src==0 or dest==5.
- States: FETCH, EXEC and HALT. Reset enters FETCH.
- FETCH:
  - Outputs mem_req=1, addr_from_pc=1, mem_we=0.
  - On mem_ready: load_ir=1 and pc_inc=1, IR<=bus_in, then go to EXEC. Otherwise stay in FETCH.
- EXEC, general:
  - src_sel_n = ~(1<<src) and do_subtract = b6 are driven for the whole state.
  - If dest==HALT: no strobes, go to HALT next cycle. retired does not increment.
- EXEC, completion:
  - If mem_cycle, completion is the first cycle with mem_ready.
  - While waiting: mem_req=1, addr_from_pc=immediate, mem_we=(dest==5).
  - If not mem_cycle, completion is the first EXEC cycle.
- Strobes on the completion cycle:
  - dest==1: load_pc = (b6&a_is_zero) | (b7&flag_carry) | (b6&b7). The flags are sampled in this cycle.
  - dest==5: there is no load_dest strobe. The write happens via mem_we.
  - Any other dest: load_dest[dest]=1.
  - pc_inc=1 when mem_cycle & immediate & ~load_pc, meaning the operand byte is consumed.
  - retired<=retired+1, wrapping modulo 2**CNT_W. Then go to FETCH.
- HALT:
  - halted=1, all other strobes 0, mem_req=0.
  - The only exit is reset.
- Every strobe lasts exactly one cycle. load_dest is never multi-hot.

## Timing
- Reset (reset_n low at a rising edge):
  - state=FETCH, IR=0, retired=0.
  - While reset_n is low, all outputs are forced low, src_sel_n is forced all-ones, and retired reads 0.
- Reset mid-wait in either state abandons the request. FETCH restarts with mem_req=1 on the first cycle after reset_n rises.
- With mem_ready tied high:
  - A non-memory instruction takes 2 cycles.
  - A memory or store instruction takes 2 cycles.
  - HALT is reached 2 cycles after fetch completes.
- Each wait cycle adds exactly 1 cycle. mem_ready is ignored when mem_req=0.
- IR is stable for all of EXEC. The flags are not latched; only the completion cycle matters.
- Outputs are combinational from state, IR and mem_ready. There are no combinational paths from a_is_zero or flag_carry other than to load_pc.

## Test plan
- Reset, then IR 0x26 (A→B: src 2, dest 3), mem_ready=1:
  - Cycle 1: load_ir=1 and pc_inc=1.
  - Cycle 2: load_dest=8'b00001000, src_sel_n=4'b1011, no mem_req.
  - retired=1.
- IR 0x04 (load A immediate from memory), with mem_ready low for 3 EXEC cycles:
  - mem_req=1 and addr_from_pc=1 are held 4 cycles.
  - load_dest[2]=1 and pc_inc=1 occur only in the 4th cycle.
- IR 0x2B (store A to [X]):
  - mem_we=1, addr_from_pc=0, load_dest=0, pc_inc=0 on completion.
- IR 0x42 (jump-if-zero): with a_is_zero=1 expect load_pc=1 and pc_inc=0; with a_is_zero=0 expect load_pc=0 and pc_inc=1.
- IR 0x3E (HALT): halted=1 from the cycle after EXEC onward, and mem_req stays 0 for more than 10 cycles. Pulsing reset_n low then returns to FETCH with halted=0 and retired=0.
- Run 65536 non-memory instructions: retired wraps to 0. Assert reset_n low mid-FETCH wait: the next cycle has mem_req=0 and all strobes 0.
